// File: rtl/conv3x3_sched_pkg.sv
// Shared constants for the 3x3x2-channel convolution scheduler and its PE.
// Also holds the per-tap PE arithmetic so the PE body stays a plain reduction.
package conv3x3_sched_pkg;

    localparam int BIT_W       = 8;
    localparam int PE_IMAGE_W  = 144;
    localparam int PE_KERNEL_W = 144;
    localparam int PE_OUT_W    = 8;
    localparam int KERNEL_TAPS = 18;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Product bits [11:3], sign-extended; anything above bit 11 is dropped.
    function automatic logic signed [8:0] pe_term(input logic signed [7:0] a,
                                                  input logic signed [7:0] b);
        return 9'((16'(a) * 16'(b)) >>> 3);
    endfunction

endpackage

// File: rtl/conv3x3_sched_if.sv
// Pixel-in and result-out streams of the scheduler.
// Both streams: a beat transfers on a rising clock edge where valid and ready are
// both high; the producer holds valid and data stable until that beat happens.
interface conv3x3_sched_if;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic [15:0] i_pix_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [7:0]  o_out_data;

    modport slave  (input  i_pix_valid, i_pix_data, i_out_ready,
                    output o_pix_ready, o_out_valid, o_out_data);
    modport master (output i_pix_valid, i_pix_data, i_out_ready,
                    input  o_pix_ready, o_out_valid, o_out_data);
endinterface

// File: rtl/conv3x3_linebuf.sv
// Two row buffers plus the 2-channel 3x3 window; o_win is the window as it will
// be after the current pixel is shifted in, so the result can be registered on accept.
module conv3x3_linebuf
    import conv3x3_sched_pkg::*;
#(
    parameter int MAX_W = 16,
    parameter int AW    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_shift,
    input  logic [AW-1:0]         i_col,
    input  logic [15:0]           i_pix,
    output logic [PE_IMAGE_W-1:0] o_win
);

    logic [15:0]           lb0_q [MAX_W];
    logic [15:0]           lb1_q [MAX_W];
    logic [15:0]           col_src [3];
    logic [PE_IMAGE_W-1:0] win_q, win_d;

    // Tap index = ch*9 + row*3 + col; row 0 is the oldest image row, col 0 the oldest column.
    always_comb begin
        col_src[0] = lb1_q[i_col];
        col_src[1] = lb0_q[i_col];
        col_src[2] = i_pix;
        win_d      = win_q;
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 3; r++) begin
                win_d[(ch*9+r*3)*BIT_W +: BIT_W]   = win_q[(ch*9+r*3+1)*BIT_W +: BIT_W];
                win_d[(ch*9+r*3+1)*BIT_W +: BIT_W] = win_q[(ch*9+r*3+2)*BIT_W +: BIT_W];
                win_d[(ch*9+r*3+2)*BIT_W +: BIT_W] = (ch == 0) ? col_src[r][15:8]
                                                               : col_src[r][7:0];
            end
        end
    end

    assign o_win = win_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_W; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            win_q <= '0;
        end else if (i_shift) begin
            win_q        <= win_d;
            lb1_q[i_col] <= lb0_q[i_col];
            lb0_q[i_col] <= i_pix;
        end
    end

endmodule

// File: rtl/conv3x3_pe.sv
// Combinational 3x3x2-channel PE: 18 signed 8-bit products, each >>3, summed.
// Only the low 8 bits of the sum leave the PE, so accumulating modulo 2^8 is exact.
module conv3x3_pe
    import conv3x3_sched_pkg::*;
(
    input  logic [PE_IMAGE_W-1:0]  i_image,
    input  logic [PE_KERNEL_W-1:0] i_kernel,
    output logic [PE_OUT_W-1:0]    o_result
);

    always_comb begin
        o_result = '0;
        for (int i = 0; i < KERNEL_TAPS; i++) begin
            o_result = o_result + 8'(pe_term(i_image[i*BIT_W +: BIT_W],
                                             i_kernel[i*BIT_W +: BIT_W]));
        end
    end

endmodule

// File: rtl/conv3x3_sched.sv
// Streaming scheduler: loads 18 weights in IDLE, walks a raster 2-channel image in
// RUN, emits one registered PE result per valid (no-padding) window position.
module conv3x3_sched
    import conv3x3_sched_pkg::*;
#(
    parameter int MAX_W = 16,
    parameter int DIM_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DIM_W-1:0] i_img_w,
    input  logic [DIM_W-1:0] i_img_h,
    input  logic             i_k_valid,
    input  logic [7:0]       i_k_data,
    conv3x3_sched_if.slave   bus,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [1:0]       o_dbg_state
);

    localparam int LB_AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int KI_W  = $clog2(KERNEL_TAPS);

    logic [1:0]             state_q, state_d;
    logic [DIM_W-1:0]       w_q, h_q, row_q, col_q;
    logic [KI_W-1:0]        k_idx_q;
    logic [BIT_W-1:0]       kernel_q [KERNEL_TAPS];
    logic [PE_KERNEL_W-1:0] kernel_flat;
    logic [PE_IMAGE_W-1:0]  win;
    logic [PE_OUT_W-1:0]    pe_result;
    logic                   out_valid_q, done_q, err_q;
    logic [PE_OUT_W-1:0]    out_data_q;
    logic                   legal, pix_ready, accept, pop, last_col, last_pix, emit;

    always_comb begin
        legal     = (i_img_w >= DIM_W'(3)) && (i_img_w <= DIM_W'(MAX_W)) &&
                    (i_img_h >= DIM_W'(3));
        pix_ready = (state_q == RUN) && (!out_valid_q || bus.i_out_ready);
        accept    = bus.i_pix_valid && pix_ready;
        pop       = out_valid_q && bus.i_out_ready;
        last_col  = (col_q == w_q - DIM_W'(1));
        last_pix  = last_col && (row_q == h_q - DIM_W'(1));
        emit      = accept && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));
        kernel_flat = '0;
        for (int i = 0; i < KERNEL_TAPS; i++) kernel_flat[i*BIT_W +: BIT_W] = kernel_q[i];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start && legal)     state_d = RUN;
            RUN:     if (accept && last_pix)   state_d = DRAIN;
            DRAIN:   if (!out_valid_q || pop)  state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    conv3x3_linebuf #(.MAX_W(MAX_W), .AW(LB_AW)) u_linebuf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_shift (accept),
        .i_col   (col_q[LB_AW-1:0]),
        .i_pix   (bus.i_pix_data),
        .o_win   (win)
    );

    conv3x3_pe u_pe (.i_image(win), .i_kernel(kernel_flat), .o_result(pe_result));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            k_idx_q     <= '0;
            for (int i = 0; i < KERNEL_TAPS; i++) kernel_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_k_valid) begin
                        kernel_q[k_idx_q] <= i_k_data;
                        k_idx_q <= (k_idx_q == KI_W'(KERNEL_TAPS-1)) ? '0 : k_idx_q + KI_W'(1);
                    end
                    // A start in the same cycle as a weight write still resets the index.
                    if (i_start && legal) begin
                        w_q     <= i_img_w;
                        h_q     <= i_img_h;
                        row_q   <= '0;
                        col_q   <= '0;
                        k_idx_q <= '0;
                    end else if (i_start) begin
                        err_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        col_q <= last_col ? '0 : col_q + DIM_W'(1);
                        if (last_col) row_q <= row_q + DIM_W'(1);
                    end
                end
                DRAIN: if (!out_valid_q || pop) done_q <= 1'b1;
                default: ;
            endcase
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= pe_result;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_pix_ready = pix_ready;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_out_data  = out_data_q;
    assign o_busy          = (state_q == RUN) || (state_q == DRAIN);
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_conv3x3_sched.sv
// Bench for conv3x3_sched: frames driven in raster order, results checked
// against a reference convolution through an expected-value queue.
module tb_conv3x3_sched;
    import conv3x3_sched_pkg::*;

    localparam int MAX_W = 16;
    localparam int DIM_W = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             start;
    logic [DIM_W-1:0] img_w, img_h;
    logic             k_valid;
    logic [7:0]       k_data;
    logic             busy, done, err;
    logic [1:0]       dbg_state;

    conv3x3_sched_if bus ();

    conv3x3_sched #(.MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_img_w     (img_w),
        .i_img_h     (img_h),
        .i_k_valid   (k_valid),
        .i_k_data    (k_data),
        .bus         (bus),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- bench state ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] kmodel [18];
    logic [15:0] img [8][16];
    int         stall_cnt;
    bit         k_noise = 1'b0;
    int         ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference window result for the output produced when pixel (r,c) is accepted.
    function automatic logic [7:0] model_out(input int r, input int c);
        int sum = 0;
        for (int ch = 0; ch < 2; ch++) begin
            for (int wr = 0; wr < 3; wr++) begin
                for (int wc = 0; wc < 3; wc++) begin
                    logic [15:0]       px16;
                    logic signed [7:0] px, kv;
                    int a, b, t;
                    px16 = img[r-2+wr][c-2+wc];
                    px   = (ch == 0) ? px16[15:8] : px16[7:0];
                    kv   = kmodel[ch*9+wr*3+wc];
                    a = px;
                    b = kv;
                    t = ((a * b) >>> 3) & 'h1FF;
                    if (t > 255) t -= 512;
                    sum += t;
                end
            end
        end
        return 8'(sum);
    endfunction

    // Result-ready driver; the only writer of i_out_ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       bus.i_out_ready = ($urandom_range(0, 3) != 0);
            2:       bus.i_out_ready = 1'b0;
            default: bus.i_out_ready = 1'b1;
        endcase
    end

    // Scoreboard: every transferred result is popped and compared.
    always @(negedge clk) begin
        if (!rst && bus.o_out_valid && bus.i_out_ready) begin
            if (exp_q.size() == 0) check_eq("out_extra", 32'(exp_q.size()), 32'd1);
            else                   check_eq("out_data", 32'(bus.o_out_data), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_kernel(input logic [7:0] k [18]);
        for (int i = 0; i < 18; i++) begin
            k_valid   = 1'b1;
            k_data    = k[i];
            kmodel[i] = k[i];
            tick();
        end
        k_valid = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h);
        img_w = DIM_W'(w);
        img_h = DIM_W'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_run", 32'(busy), 32'd1);
    endtask

    task automatic drive_pixel(input logic [15:0] d);
        int n = 0;
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = d;
        if (k_noise) begin
            k_valid = 1'b1;
            k_data  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        while (!bus.o_pix_ready && n < 200) begin
            stall_cnt++;
            n++;
            @(negedge clk);
        end
        if (n >= 200) check_eq("pix_ready_timeout", 32'(bus.o_pix_ready), 32'd1);
        tick();
    endtask

    task automatic wait_done();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // mode 0: all 0x0101, 1: ch0=col, 2: ch0=10r+c, 3: random, 4: all 0x7F7F.
    // fixed >= 0 replaces the model with a hand-derived constant.
    task automatic run_frame(input int w, input int h, input int mode, input int fixed);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                case (mode)
                    0:       img[r][c] = 16'h0101;
                    1:       img[r][c] = {8'(c), 8'h00};
                    2:       img[r][c] = {8'(10*r + c), 8'h00};
                    3:       img[r][c] = 16'($urandom_range(0, 65535));
                    default: img[r][c] = 16'h7F7F;
                endcase
            end
        end
        start_frame(w, h);
        stall_cnt = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r >= 2 && c >= 2) exp_q.push_back((fixed >= 0) ? 8'(fixed) : model_out(r, c));
                drive_pixel(img[r][c]);
            end
        end
        bus.i_pix_valid = 1'b0;
        k_valid         = 1'b0;
        wait_done();
    endtask

    // ---------------- test sequence ----------------
    logic [7:0] kern [18];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        img_w = '0;
        img_h = '0;
        k_valid = 1'b0;
        k_data = '0;
        bus.i_pix_valid = 1'b0;
        bus.i_pix_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pix_ready", 32'(bus.o_pix_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // All-ones kernel on a 3x3 frame of 1s: single output 18.
        for (int i = 0; i < 18; i++) kern[i] = 8'd8;
        load_kernel(kern);
        run_frame(3, 3, 0, 'h12);

        // Column ramp on ch0, full throughput expected.
        run_frame(4, 3, 1, -1);
        check_eq("no_stall", 32'(stall_cnt), 32'd0);

        // Centre-tap kernel with the result stream held off for 4 cycles.
        for (int i = 0; i < 18; i++) kern[i] = 8'd0;
        kern[4] = 8'd8;
        load_kernel(kern);
        fork
            run_frame(5, 4, 2, -1);
            begin
                int n = 0;
                while (exp_q.size() == 0 && n < 2000) begin #1; n++; end
                ready_mode = 2;
                n = 0;
                @(negedge clk);
                while (!bus.o_out_valid && n < 100) begin @(negedge clk); n++; end
                check_eq("hold_valid", 32'(bus.o_out_valid), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    check_eq("hold_data", 32'(bus.o_out_data), 32'(exp_q[0]));
                    check_eq("hold_pix_ready", 32'(bus.o_pix_ready), 32'd0);
                    @(negedge clk);
                end
                ready_mode = 0;
            end
        join

        // Illegal starts.
        for (int t = 0; t < 3; t++) begin
            img_w = (t == 0) ? DIM_W'(2) : (t == 1) ? DIM_W'(MAX_W + 1) : DIM_W'(5);
            img_h = (t == 2) ? DIM_W'(2) : DIM_W'(4);
            start = 1'b1;
            tick();
            start = 1'b0;
            @(negedge clk);
            check_eq("err_pulse", 32'(err), 32'd1);
            check_eq("err_state", 32'(dbg_state), 32'(IDLE));
            check_eq("err_busy", 32'(busy), 32'd0);
            @(negedge clk);
            check_eq("err_clear", 32'(err), 32'd0);
            tick();
        end

        // Random kernel; weight writes during RUN must be ignored, so a second
        // frame with the same kernel model must still match.
        for (int i = 0; i < 18; i++) kern[i] = 8'($urandom_range(0, 255));
        load_kernel(kern);
        k_noise = 1'b1;
        run_frame(6, 5, 3, -1);
        k_noise = 1'b0;
        run_frame(7, 4, 3, -1);

        // Maximum width with random backpressure on results.
        ready_mode = 1;
        run_frame(MAX_W, 3, 3, -1);
        ready_mode = 0;
        tick();

        // Saturating inputs: every term is -127, the sum wraps to 0x12.
        for (int i = 0; i < 18; i++) kern[i] = 8'hF8;
        load_kernel(kern);
        run_frame(3, 3, 4, 'h12);

        // Reset part-way through a frame.
        for (int i = 0; i < 18; i++) kern[i] = 8'd0;
        kern[4] = 8'd8;
        load_kernel(kern);
        start_frame(5, 4);
        for (int i = 0; i < 5; i++) drive_pixel(16'h1234);
        bus.i_pix_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_pix_ready", 32'(bus.o_pix_ready), 32'd0);
        check_eq("mid_rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check_eq("mid_rst_out_data", 32'(bus.o_out_data), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_err", 32'(err), 32'd0);
        check_eq("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        load_kernel(kern);
        run_frame(5, 4, 2, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
